// File: rtl/peripheral_wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave.
// A one-hot grant register selects the owner, and the owner keeps the bus until it drops cyc.
module peripheral_wb_arbiter #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int NUM_MASTERS = 2
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [DW-1:0]               wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = DW / 8;

    logic [NUM_MASTERS-1:0] grant;
    logic [NUM_MASTERS-1:0] rr_grant;
    logic [IW-1:0]          master_sel;
    logic [IW-1:0]          rr_start;
    logic [IW-1:0]          rr_winner;
    logic [IW:0]            rr_idx;
    logic                   rr_found;
    logic                   grant_valid;
    logic                   owner_cyc;
    int                     sel_i;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        master_sel = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) master_sel = IW'(i);
        end
    end

    assign grant_valid = |grant;
    assign owner_cyc   = grant_valid & wbm_cyc_i[master_sel];
    assign sel_i       = int'(master_sel);

    // Scan requests starting at rr_start, wrapping at NUM_MASTERS; first requester wins.
    always_comb begin
        rr_grant  = '0;
        rr_winner = '0;
        rr_found  = 1'b0;
        rr_idx    = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            rr_idx = {1'b0, rr_start} + (IW+1)'(k);
            if (rr_idx >= (IW+1)'(NUM_MASTERS)) rr_idx = rr_idx - (IW+1)'(NUM_MASTERS);
            if (!rr_found && wbm_cyc_i[rr_idx[IW-1:0]]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx[IW-1:0];
            end
        end
        if (rr_found) rr_grant[rr_winner] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            grant    <= '0;
            rr_start <= '0;
        end else if (!owner_cyc) begin
            grant <= rr_grant;
            if (rr_found) begin
                rr_start <= (rr_winner == IW'(NUM_MASTERS - 1)) ? '0 : rr_winner + 1'b1;
            end
        end
    end

    assign wbs_adr_o = wbm_adr_i[sel_i*AW +: AW];
    assign wbs_dat_o = wbm_dat_i[sel_i*DW +: DW];
    assign wbs_sel_o = wbm_sel_i[sel_i*SW +: SW];
    assign wbs_we_o  = wbm_we_i[master_sel];
    assign wbs_cti_o = wbm_cti_i[sel_i*3 +: 3];
    assign wbs_bte_o = wbm_bte_i[sel_i*2 +: 2];
    assign wbs_cyc_o = grant_valid & wbm_cyc_i[master_sel];
    assign wbs_stb_o = grant_valid & wbm_stb_i[master_sel];

    // Terminations go only to the owner; an all-zero grant silences them all.
    assign wbm_ack_o = grant & {NUM_MASTERS{wbs_ack_i}};
    assign wbm_err_o = grant & {NUM_MASTERS{wbs_err_i}};
    assign wbm_rty_o = grant & {NUM_MASTERS{wbs_rty_i}};
    assign wbm_dat_o = wbs_dat_i;

endmodule

// File: tb/tb_peripheral_wb_arbiter.sv
// Bench for peripheral_wb_arbiter: directed scenarios plus randomized traffic,
// all compared against an owner/pointer reference model.
module tb_peripheral_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int N  = 3;

    logic                 wb_clk_i = 1'b0;
    logic                 wb_rst_ni = 1'b0;
    logic [N*AW-1:0]      wbm_adr_i = '0;
    logic [N*DW-1:0]      wbm_dat_i = '0;
    logic [N*DW/8-1:0]    wbm_sel_i = '0;
    logic [N-1:0]         wbm_we_i = '0;
    logic [N-1:0]         wbm_cyc_i = '0;
    logic [N-1:0]         wbm_stb_i = '0;
    logic [N*3-1:0]       wbm_cti_i = '0;
    logic [N*2-1:0]       wbm_bte_i = '0;
    logic [DW-1:0]        wbm_dat_o;
    logic [N-1:0]         wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [AW-1:0]        wbs_adr_o;
    logic [DW-1:0]        wbs_dat_o;
    logic [DW/8-1:0]      wbs_sel_o;
    logic                 wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]           wbs_cti_o;
    logic [1:0]           wbs_bte_o;
    logic [DW-1:0]        wbs_dat_i = '0;
    logic                 wbs_ack_i = 1'b0, wbs_err_i = 1'b0, wbs_rty_i = 1'b0;

    peripheral_wb_arbiter #(.DW(DW), .AW(AW), .NUM_MASTERS(N)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, and where the next fair search begins.
    int owner    = -1;
    int rr_start = 0;

    task automatic model_edge();
        if (!wb_rst_ni) begin
            owner    = -1;
            rr_start = 0;
        end else if (owner < 0 || !wbm_cyc_i[owner]) begin
            owner = -1;
            for (int k = 0; k < N; k++) begin
                int m;
                m = (rr_start + k) % N;
                if (wbm_cyc_i[m]) begin
                    owner = m;
                    break;
                end
            end
            if (owner >= 0) rr_start = (owner + 1) % N;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] onehot;
        onehot = '0;
        if (owner >= 0) begin
            onehot[owner] = 1'b1;
            check("adr", 64'(wbs_adr_o), 64'(wbm_adr_i[owner*AW +: AW]));
            check("dat", 64'(wbs_dat_o), 64'(wbm_dat_i[owner*DW +: DW]));
            check("sel", 64'(wbs_sel_o), 64'(wbm_sel_i[owner*(DW/8) +: DW/8]));
            check("we",  64'(wbs_we_o),  64'(wbm_we_i[owner]));
            check("cti", 64'(wbs_cti_o), 64'(wbm_cti_i[owner*3 +: 3]));
            check("bte", 64'(wbs_bte_o), 64'(wbm_bte_i[owner*2 +: 2]));
            check("cyc", 64'(wbs_cyc_o), 64'(wbm_cyc_i[owner]));
            check("stb", 64'(wbs_stb_o), 64'(wbm_stb_i[owner]));
        end else begin
            check("cyc_idle", 64'(wbs_cyc_o), 64'(0));
            check("stb_idle", 64'(wbs_stb_o), 64'(0));
        end
        check("ack",  64'(wbm_ack_o), 64'(wbs_ack_i ? onehot : '0));
        check("err",  64'(wbm_err_o), 64'(wbs_err_i ? onehot : '0));
        check("rty",  64'(wbm_rty_o), 64'(wbs_rty_i ? onehot : '0));
        check("rdat", 64'(wbm_dat_o), 64'(wbs_dat_i));
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_m(input int m, input logic cyc, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [2:0] cti);
        wbm_cyc_i[m]              = cyc;
        wbm_stb_i[m]              = cyc;
        wbm_we_i[m]               = 1'b1;
        wbm_adr_i[m*AW +: AW]     = adr;
        wbm_dat_i[m*DW +: DW]     = dat;
        wbm_sel_i[m*(DW/8) +: DW/8] = '1;
        wbm_cti_i[m*3 +: 3]       = cti;
        wbm_bte_i[m*2 +: 2]       = 2'b00;
    endtask

    task automatic drop_all();
        wbm_cyc_i = '0;
        wbm_stb_i = '0;
    endtask

    initial begin
        int exp_o;

        // Reset holds the bus idle even with a request pending.
        set_m(0, 1'b1, 32'h100, 32'hA5A5_A5A5, 3'b000);
        step();
        step();
        check("rst_cyc", 64'(wbs_cyc_o), 64'(0));
        check("rst_ack", 64'(wbm_ack_o), 64'(0));

        // Single master write.
        wb_rst_ni = 1'b1;
        step();
        check("single_cyc", 64'(wbs_cyc_o), 64'(1));
        check("single_adr", 64'(wbs_adr_o), 64'h100);
        check("single_dat", 64'(wbs_dat_o), 64'hA5A5_A5A5);
        wbs_ack_i = 1'b1;
        #1;
        check("single_ack", 64'(wbm_ack_o), 64'(3'b001));
        wbs_ack_i = 1'b0;
        drop_all();
        step();

        // Contention straight after reset: m0 wins, m1 follows without a gap.
        wb_rst_ni = 1'b0;
        step();
        wb_rst_ni = 1'b1;
        set_m(0, 1'b1, 32'h100, 32'h0000_0000, 3'b000);
        set_m(1, 1'b1, 32'h200, 32'h1111_1111, 3'b000);
        step();
        check("cont_first", 64'(wbs_adr_o), 64'h100);
        wbm_cyc_i[0] = 1'b0;
        wbm_stb_i[0] = 1'b0;
        step();
        check("cont_second", 64'(wbs_adr_o), 64'h200);
        check("cont_nogap", 64'(wbs_cyc_o), 64'(1));

        // Fairness: owner ends after one transfer, then requests again.
        wbm_cyc_i[0] = 1'b1;
        wbm_stb_i[0] = 1'b1;
        exp_o = 1;
        for (int i = 0; i < 4; i++) begin
            wbm_cyc_i[exp_o] = 1'b0;
            step();
            wbm_cyc_i[exp_o] = 1'b1;
            exp_o = 1 - exp_o;
            #1;
            check("fair_owner", 64'(wbs_adr_o), exp_o ? 64'h200 : 64'h100);
        end

        // Burst lock: m1 keeps the bus for 4 beats despite m0 requesting.
        drop_all();
        step();
        set_m(1, 1'b1, 32'h200, 32'h2222_2222, 3'b010);
        step();
        set_m(0, 1'b1, 32'h100, 32'h3333_3333, 3'b000);
        for (int b = 0; b < 4; b++) begin
            wbs_ack_i = 1'b1;
            #1;
            check("burst_owner", 64'(wbs_adr_o), 64'h200);
            check("burst_ack", 64'(wbm_ack_o), 64'(3'b010));
            step();
        end
        wbs_ack_i = 1'b0;
        wbm_cyc_i[1] = 1'b0;
        wbm_stb_i[1] = 1'b0;
        step();
        check("burst_handoff", 64'(wbs_adr_o), 64'h100);

        // Error and retry routing to owner m1.
        drop_all();
        step();
        set_m(1, 1'b1, 32'h200, 32'h4444_4444, 3'b000);
        step();
        wbs_err_i = 1'b1;
        #1;
        check("err_route", 64'(wbm_err_o), 64'(3'b010));
        check("err_noack", 64'(wbm_ack_o), 64'(0));
        wbs_err_i = 1'b0;
        wbs_rty_i = 1'b1;
        #1;
        check("rty_route", 64'(wbm_rty_o), 64'(3'b010));
        check("rty_noack", 64'(wbm_ack_o), 64'(0));
        wbs_rty_i = 1'b0;

        // Reset in the middle of m1's transfer aborts it; m1 is re-granted afterwards.
        wbs_ack_i = 1'b1;
        wb_rst_ni = 1'b0;
        step();
        check("abort_cyc", 64'(wbs_cyc_o), 64'(0));
        check("abort_ack", 64'(wbm_ack_o), 64'(0));
        wb_rst_ni = 1'b1;
        wbs_ack_i = 1'b0;
        step();
        check("regrant_cyc", 64'(wbs_cyc_o), 64'(1));
        check("regrant_adr", 64'(wbs_adr_o), 64'h200);

        // Randomized traffic, including occasional resets.
        for (int c = 0; c < 2000; c++) begin
            for (int m = 0; m < N; m++) begin
                if (wbm_cyc_i[m]) wbm_cyc_i[m] = ($urandom_range(0, 3) != 0);
                else              wbm_cyc_i[m] = ($urandom_range(0, 2) == 0);
                wbm_stb_i[m] = 1'($urandom);
                wbm_we_i[m]  = 1'($urandom);
                wbm_adr_i[m*AW +: AW] = $urandom;
                wbm_dat_i[m*DW +: DW] = $urandom;
                wbm_sel_i[m*(DW/8) +: DW/8] = 4'($urandom);
                wbm_cti_i[m*3 +: 3] = 3'($urandom);
                wbm_bte_i[m*2 +: 2] = 2'($urandom);
            end
            wbs_dat_i = $urandom;
            wbs_ack_i = 1'($urandom);
            wbs_err_i = ($urandom_range(0, 7) == 0);
            wbs_rty_i = ($urandom_range(0, 7) == 0);
            wb_rst_ni = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
